// File: rtl/bspline_pkg.sv
// Shared definitions for the B-spline datapath: knot count, locator FSM
// states and the clamp-flag pair that travels with each located operand.
package bspline_pkg;

  localparam int GRID_SIZE_DEF = 8;
  localparam int DEGREE_DEF    = 3;

  function automatic int num_knots(input int grid_size, input int degree);
    return grid_size + degree + 1;
  endfunction

  localparam int NUM_KNOTS = num_knots(GRID_SIZE_DEF, DEGREE_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_HOLD   = 2'd3
  } loc_state_e;

  typedef struct packed {
    logic unf;
    logic ovf;
  } clamp_flags_t;

endpackage

// File: rtl/bspline_frac_divider.sv
// Restoring divider producing the Q0.FRAC_WIDTH quotient (num << FRAC_WIDTH) / den.
// The start cycle already performs the first iteration; done pulses once, after the last.
module bspline_frac_divider
  import bspline_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] num_i,
  input  logic [DATA_WIDTH-1:0] den_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [FRAC_WIDTH-1:0] quo_o
);

  localparam int CNT_W = $clog2(FRAC_WIDTH + 1);

  logic [DATA_WIDTH-1:0] rem_q, rem_d, rem_in, den_q, den_sel;
  logic [FRAC_WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q, sat_q;
  logic [DATA_WIDTH:0]   shifted;
  logic                  ge;

  always_comb begin
    rem_in  = start_i ? num_i : rem_q;
    den_sel = start_i ? den_i : den_q;
    shifted = {rem_in, 1'b0};
    ge      = shifted >= {1'b0, den_sel};
    rem_d   = ge ? DATA_WIDTH'(shifted - {1'b0, den_sel}) : shifted[DATA_WIDTH-1:0];
    quo_d   = start_i ? {{(FRAC_WIDTH-1){1'b0}}, ge} : {quo_q[FRAC_WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_i;
      // A numerator not below the denominator cannot fit in a pure fraction.
      sat_q  <= num_i >= den_i;
      cnt_q  <= CNT_W'(FRAC_WIDTH - 1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quo_o  = sat_q ? '1 : quo_q;

endmodule

// File: rtl/bspline_knot_locator.sv
// Finds the knot span holding each sample and its normalized local coordinate.
// Optional saturating clamp counters are built when BSPLINE_LOC_CLAMP_CNT_EN is defined.
module bspline_knot_locator
  import bspline_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GRID_SIZE  = 8,
  parameter int DEGREE     = 3,
  parameter int FRAC_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  knot_wr_en,
  input  logic [IDX_WIDTH-1:0]  knot_wr_addr,
  input  logic [DATA_WIDTH-1:0] knot_wr_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [FRAC_WIDTH-1:0] out_frac,
  output logic                  out_unf,
  output logic                  out_ovf,
  output logic [15:0]           unf_cnt,
  output logic [15:0]           ovf_cnt
);

  // valid/ready: a transfer occurs on a rising edge where both are high; the
  // producer keeps its payload stable while valid is high and ready is low.

  localparam int NUM_KNOTS_L = num_knots(GRID_SIZE, DEGREE);
  localparam logic [IDX_WIDTH-1:0] DEG_IDX  = IDX_WIDTH'(DEGREE);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GRID_SIZE - 1);

  loc_state_e            state_q;
  logic [DATA_WIDTH-1:0] knot_q [NUM_KNOTS_L];
  logic [DATA_WIDTH-1:0] x_q;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_nxt, idx_q;
  logic [FRAC_WIDTH-1:0] frac_q;
  clamp_flags_t          clamp_q;
  logic                  in_ready_q, out_valid_q;

  logic                  unf_hit, span_hit, div_start, div_busy, div_done, knot_wr_ok;
  logic [DATA_WIDTH-1:0] div_num, div_den;
  logic [FRAC_WIDTH-1:0] div_quo;

  always_comb begin
    ptr_nxt    = ptr_q + 1'b1;
    unf_hit    = (ptr_q == DEG_IDX) && (x_q < knot_q[DEG_IDX]);
    span_hit   = x_q < knot_q[ptr_nxt];
    div_start  = (state_q == ST_SEARCH) && !unf_hit && span_hit;
    div_num    = x_q - knot_q[ptr_q];
    div_den    = knot_q[ptr_nxt] - knot_q[ptr_q];
    knot_wr_ok = (state_q == ST_IDLE) && knot_wr_en &&
                 ({1'b0, knot_wr_addr} < (IDX_WIDTH+1)'(NUM_KNOTS_L));
  end

  bspline_frac_divider #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(div_start),
    .num_i  (div_num),
    .den_i  (div_den),
    .busy_o (div_busy),
    .done_o (div_done),
    .quo_o  (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_KNOTS_L; i++) knot_q[i] <= '0;
      x_q         <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      frac_q      <= '0;
      clamp_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // A write alongside an accepted sample commits first, so the search sees it.
      if (knot_wr_ok) knot_q[knot_wr_addr] <= knot_wr_data;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q        <= in_x;
            ptr_q      <= DEG_IDX;
            in_ready_q <= 1'b0;
            state_q    <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (unf_hit) begin
            idx_q       <= DEG_IDX;
            frac_q      <= '0;
            clamp_q     <= '{unf: 1'b1, ovf: 1'b0};
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else if (span_hit) begin
            idx_q   <= ptr_q;
            state_q <= ST_DIVIDE;
          end else if (ptr_q == LAST_IDX) begin
            idx_q       <= LAST_IDX;
            frac_q      <= '1;
            clamp_q     <= '{unf: 1'b0, ovf: 1'b1};
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else begin
            ptr_q <= ptr_nxt;
          end
        end
        ST_DIVIDE: begin
          if (div_done && !div_busy) begin
            frac_q      <= div_quo;
            clamp_q     <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = x_q;
  assign out_idx   = idx_q;
  assign out_frac  = frac_q;
  assign out_unf   = clamp_q.unf;
  assign out_ovf   = clamp_q.ovf;

`ifdef BSPLINE_LOC_CLAMP_CNT_EN
  logic [15:0] unf_cnt_q, ovf_cnt_q;
  logic        out_hs;

  assign out_hs = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unf_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else if (out_hs) begin
      if (clamp_q.unf && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 1'b1;
      if (clamp_q.ovf && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign unf_cnt = unf_cnt_q;
  assign ovf_cnt = ovf_cnt_q;
`else
  assign unf_cnt = '0;
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_bspline_knot_locator.sv
// Directed bench for bspline_knot_locator with a reference span/fraction model
// feeding an expected-result queue.
module tb_bspline_knot_locator;

  typedef struct packed {
    logic [7:0]  lat;
    logic [15:0] x;
    logic [3:0]  idx;
    logic [15:0] frac;
    logic        unf;
    logic        ovf;
  } exp_t;
  localparam int EW = $bits(exp_t);

`ifdef BSPLINE_LOC_CLAMP_CNT_EN
  localparam logic [15:0] CNT_ONE = 16'd1;
`else
  localparam logic [15:0] CNT_ONE = 16'd0;
`endif

  logic        clk, rst_n;
  logic        knot_wr_en;
  logic [3:0]  knot_wr_addr;
  logic [15:0] knot_wr_data;
  logic        in_valid, in_ready;
  logic [15:0] in_x;
  logic        out_valid, out_ready;
  logic [15:0] out_x;
  logic [3:0]  out_idx;
  logic [15:0] out_frac;
  logic        out_unf, out_ovf;
  logic [15:0] unf_cnt, ovf_cnt;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   mdl_knot [12];
  int cyc = 0;
  int acc_edge = 0;
  int n_checks = 0;
  int n_pass = 0;

  bspline_knot_locator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .knot_wr_en  (knot_wr_en),
    .knot_wr_addr(knot_wr_addr),
    .knot_wr_data(knot_wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_idx     (out_idx),
    .out_frac    (out_frac),
    .out_unf     (out_unf),
    .out_ovf     (out_ovf),
    .unf_cnt     (unf_cnt),
    .ovf_cnt     (ovf_cnt)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: linear span search plus exact integer division
  function automatic exp_t model(input logic [15:0] x);
    exp_t   e;
    longint num, den, q;
    bit     found;
    e = '0;
    e.x = x;
    e.idx = 4'd3;
    found = 1'b0;
    if (x < mdl_knot[3]) begin
      e.unf = 1'b1;
      e.lat = 8'd1;
    end else begin
      for (int i = 3; i <= 7; i++)
        if (!found && x < mdl_knot[i+1]) begin
          e.idx = 4'(i);
          found = 1'b1;
        end
      if (!found) begin
        e.idx  = 4'd7;
        e.frac = 16'hFFFF;
        e.ovf  = 1'b1;
        e.lat  = 8'd5;
      end else begin
        num = longint'(x - mdl_knot[e.idx]) << 16;
        den = longint'(mdl_knot[e.idx + 4'd1] - mdl_knot[e.idx]);
        q = num / den;
        e.frac = (q > 65535) ? 16'hFFFF : 16'(q);
        e.lat  = 8'(int'(e.idx) + 14);
      end
    end
    return e;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic write_knot(input logic [3:0] a, input logic [15:0] d, input bit commit);
    knot_wr_en = 1'b1;
    knot_wr_addr = a;
    knot_wr_data = d;
    if (commit) mdl_knot[a] = d;
    @(negedge clk);
    knot_wr_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] x);
    int t;
    t = 0;
    in_x = x;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(model(x));
    @(negedge clk);
    acc_edge = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, "_x"},    32'(out_x),          32'(e.x));
    check({tag, "_idx"},  32'(out_idx),        32'(e.idx));
    check({tag, "_frac"}, 32'(out_frac),       32'(e.frac));
    check({tag, "_unf"},  32'(out_unf),        32'(e.unf));
    check({tag, "_ovf"},  32'(out_ovf),        32'(e.ovf));
    check({tag, "_lat"},  32'(cyc - acc_edge), 32'(e.lat));
  endtask

  task automatic pop_compare(input string tag, output exp_t e);
    e = '0;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s_sb: observed an output, expected none queued", tag);
    end else begin
      e = exp_t'(exp_q.pop_front());
      compare(tag, e);
    end
  endtask

  task automatic receive(input string tag);
    exp_t e;
    wait_valid(tag);
    pop_compare(tag, e);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] init_k [12];
    exp_t e;
    int   stable_err;

    init_k = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd4096, 16'd8192, 16'd12288,
               16'd16384, 16'd20480, 16'd20480, 16'd20480, 16'd20480};
    for (int i = 0; i < 12; i++) mdl_knot[i] = 16'd0;
    rst_n = 1'b0;
    knot_wr_en = 1'b0;
    knot_wr_addr = '0;
    knot_wr_data = '0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_x",     32'(out_x),     32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_frac",  32'(out_frac),  32'd0);
    check("rst_out_unf",   32'(out_unf),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_unf_cnt",   32'(unf_cnt),   32'd0);
    check("rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) write_knot(4'(i), init_k[i], 1'b1);

    // in-range samples
    send(16'd5000);
    wait_valid("x5000");
    check("x5000_idx_spec",  32'(out_idx),  32'd4);
    check("x5000_frac_spec", 32'(out_frac), 32'd14464);
    check("x5000_lat_spec",  32'(cyc - acc_edge), 32'd18);
    pop_compare("x5000", e);
    @(negedge clk);
    send(16'd16383);
    receive("x16383");
    send(16'd0);
    receive("x0");
    send(16'd20480);
    receive("x20480");

    // knot write coinciding with an accepted sample
    knot_wr_en = 1'b1;
    knot_wr_addr = 4'd3;
    knot_wr_data = 16'd100;
    in_x = 16'd50;
    in_valid = 1'b1;
    mdl_knot[3] = 16'd100;
    exp_q.push_back(model(16'd50));
    @(negedge clk);
    acc_edge = cyc;
    knot_wr_en = 1'b0;
    in_valid = 1'b0;
    receive("x50");
    check("cnt_unf_a", 32'(unf_cnt), 32'(CNT_ONE));
    check("cnt_ovf_a", 32'(ovf_cnt), 32'(CNT_ONE));

    // backpressure
    out_ready = 1'b0;
    send(16'd9000);
    wait_valid("bp");
    pop_compare("bp", e);
    in_x = 16'd3000;
    in_valid = 1'b1;
    stable_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_x !== e.x || out_idx !== e.idx ||
          out_frac !== e.frac || out_unf !== e.unf || out_ovf !== e.ovf)
        stable_err++;
    end
    check("bp_stable", 32'(stable_err), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_low", 32'(out_valid), 32'd0);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    exp_q.push_back(model(16'd3000));
    @(negedge clk);
    acc_edge = cyc;
    in_valid = 1'b0;
    check("bp_second_taken", 32'(in_ready), 32'd0);
    receive("bp2");

    // write during DIVIDE is dropped; out-of-range address is ignored
    send(16'd5000);
    repeat (3) @(negedge clk);
    write_knot(4'd4, 16'd6000, 1'b0);
    receive("div_wr");
    send(16'd5000);
    receive("div_wr_after");
    write_knot(4'd13, 16'd1, 1'b0);
    send(16'd10000);
    receive("addr13");

    // reset mid-DIVIDE
    send(16'd5000);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 12; i++) mdl_knot[i] = 16'd0;
    @(negedge clk);
    check("postrst_valid", 32'(out_valid), 32'd0);
    send(16'd1234);
    receive("postrst");
    check("cnt_unf_b", 32'(unf_cnt), 32'd0);
    check("cnt_ovf_b", 32'(ovf_cnt), 32'(CNT_ONE));
    repeat (3) @(negedge clk);
    check("no_spurious_out", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bspline_knot_locator.md
Name: bspline_knot_locator

Overview:
- Upstream stage of the B-spline evaluator in the KAN edge datapath.
- For each input sample, finds the active knot span index i, where knot[i] <= x < knot[i+1].
- Computes the fractional local coordinate (x - knot[i]) / (knot[i+1] - knot[i]) as an unsigned fixed-point fraction.
- Holds a runtime-loadable knot vector and uses valid/ready handshakes on both sides, so the evaluator receives a pre-located, normalized operand.

Parameters:
DATA_WIDTH, 16, width of input sample and knot values (unsigned)
GRID_SIZE, 8, number of basis functions / coefficients
DEGREE, 3, spline degree; NUM_KNOTS = GRID_SIZE+DEGREE+1
FRAC_WIDTH, 16, width of fractional coordinate output (Q0.FRAC_WIDTH)
IDX_WIDTH, 4, width of span index; must satisfy 2**IDX_WIDTH >= NUM_KNOTS

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
knot_wr_en  in  1  knot memory write strobe
knot_wr_addr  in  IDX_WIDTH  knot index to write
knot_wr_data  in  DATA_WIDTH  knot value
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_x  in  DATA_WIDTH  input sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_x  out  DATA_WIDTH  registered copy of the accepted sample
out_idx  out  IDX_WIDTH  span index, range DEGREE..GRID_SIZE-1
out_frac  out  FRAC_WIDTH  local coordinate within the span
out_unf  out  1  x < knot[DEGREE], clamped low
out_ovf  out  1  x >= knot[GRID_SIZE], clamped high
unf_cnt  out  16  underflow counter (optional feature)
ovf_cnt  out  16  overflow counter (optional feature)

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: all outputs 0 except in_ready=1; state IDLE; all knot memory entries 0.
- Reset mid-operation aborts the sample in flight; no output is produced for it.
- Knot writes:
  - Accepted only in IDLE and only when knot_wr_addr < NUM_KNOTS; otherwise silently dropped.
  - A write takes effect on the next cycle.
  - Knots are required to be non-decreasing; the block does not check this.
- FSM states: IDLE, SEARCH, DIVIDE, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_x, set ptr=DEGREE, go to SEARCH.
- SEARCH: one ptr per cycle.
  - First cycle, if x < knot[DEGREE]: idx=DEGREE, frac=0, unf=1, go to HOLD.
  - Else if x < knot[ptr+1]: idx=ptr, go to DIVIDE.
  - Else if ptr == GRID_SIZE-1: idx=GRID_SIZE-1, frac=all ones, ovf=1, go to HOLD.
  - Else ptr++.
  - Zero-width spans are skipped naturally by the comparison.
- DIVIDE:
  - Restoring unsigned division, exactly FRAC_WIDTH cycles.
  - Numerator: (x - knot[idx]) << FRAC_WIDTH. Denominator: knot[idx+1] - knot[idx], nonzero by construction.
  - Quotient is truncated, then saturated to all ones if it overflows FRAC_WIDTH.
  - Go to HOLD.
- HOLD:
  - out_valid=1; all out_* fields stay stable until out_ready.
  - On out_valid&&out_ready: go to IDLE. in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency from the accept edge to out_valid high:
  - Normal case: s + FRAC_WIDTH cycles, where s = idx - DEGREE + 1 search cycles.
  - Underflow: 1 cycle.
  - Overflow: GRID_SIZE - DEGREE cycles.
- Throughput: one sample in flight; in_ready=0 in SEARCH, DIVIDE and HOLD.
- Simultaneous knot_wr_en and in_valid in IDLE: the write commits and the sample is accepted; the search sees the new knot value.
- out_unf and out_ovf are mutually exclusive. Both are 0 for in-range samples, including x == knot[DEGREE] exactly.

Optional Feature:
- Macro: BSPLINE_LOC_CLAMP_CNT_EN.
- Defined:
  - unf_cnt and ovf_cnt increment on each output handshake carrying unf or ovf respectively.
  - Counters saturate at 0xFFFF and clear on reset.
- Undefined: counters are not instantiated and both ports are tied to 0.

Decomposition:
- Shared package bspline_pkg holds:
  - the localparam NUM_KNOTS expression;
  - the locator FSM state enum (IDLE/SEARCH/DIVIDE/HOLD);
  - the clamp-flag struct {unf, ovf}, also reused by the evaluator.
- One sub-module: bspline_frac_divider.
  - Sequential restoring divider with start/busy/done, FRAC_WIDTH iterations, and saturation.
  - The top-level keeps the FSM, knot memory and handshakes.

Test Plan:
Common setup for all scenarios: knots 0,0,0,0,4096,8192,12288,16384,20480,20480,20480,20480.
- x=5000, out_ready=1:
  - idx=4, frac=14464, unf=ovf=0.
  - out_valid 18 cycles after accept; out_x=5000.
- x=16383: idx=6, frac=65520. x=0: idx=3, frac=0, unf=0.
- x=20480: idx=7, frac=0xFFFF, ovf=1, latency 5 cycles. Then rewrite knot[3]=100 and send x=50: idx=3, frac=0, unf=1, latency 1 cycle.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: outputs stable, in_ready=0, second in_valid is not accepted.
  - Release out_ready: handshake, then the second sample is accepted one cycle after IDLE is re-entered.
- Knot write issued during DIVIDE: dropped; a subsequent sample still uses the old knot value. Write to addr 13: ignored.
- Reset asserted mid-DIVIDE: out_valid=0, in_ready=1, all knots 0. Any x then gives ovf=1, idx=7. Compile with BSPLINE_LOC_CLAMP_CNT_EN: ovf_cnt=1 after that handshake.
